// File: rtl/vend_controller.sv
// ---------------------------------------------------------------------------
// vend_controller
//
// Multi-product vending sequencer. It builds up coin credit, accepts a
// product selection, and runs the dispenser through a req/ack handshake.
// Change goes back one quarter at a time through a second req/ack handshake
// to the coin hopper.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   quarter       one-cycle strobe, 25c inserted
//   doller        one-cycle strobe, 100c inserted (wins over quarter)
//   sel_valid     one-cycle selection strobe
//   sel_id        product index, sampled with sel_valid
//   cancel        one-cycle refund request
//   dispense_req  dispenser request, held until dispense_ack
//   dispense_id   product being dispensed, stable while dispense_req=1
//   dispense_ack  dispenser done, single cycle
//   change_req    request to the hopper to eject one quarter
//   change_ack    hopper ejected one quarter
//   credit        current credit in cents
//   coin_reject   registered one-cycle pulse, coin refused
//   insufficient  registered one-cycle pulse, selection refused
//   busy          high while vending or returning change
// ---------------------------------------------------------------------------
module vend_controller #(
    parameter int PRICE0     = 75,
    parameter int PRICE1     = 100,
    parameter int PRICE2     = 125,
    parameter int PRICE3     = 150,
    parameter int MAX_CREDIT = 200,
    parameter int CREDIT_W   = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                quarter,
    input  logic                doller,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    output logic                dispense_req,
    output logic [1:0]          dispense_id,
    input  logic                dispense_ack,
    output logic                change_req,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam int PRICES [4] = '{PRICE0, PRICE1, PRICE2, PRICE3};

    localparam logic [CREDIT_W-1:0] QUARTER_VAL = CREDIT_W'(25);
    localparam logic [CREDIT_W-1:0] DOLLAR_VAL  = CREDIT_W'(100);
    // One extra bit so credit + coin cannot wrap before the ceiling check.
    localparam logic [CREDIT_W:0]   MAX_EXT     = (CREDIT_W+1)'(MAX_CREDIT);

    state_t                state_reg, state_next;
    logic [CREDIT_W-1:0]   credit_reg, credit_next;
    logic [1:0]            dispense_id_reg, dispense_id_next;
    logic                  coin_reject_reg, coin_reject_next;
    logic                  insufficient_reg, insufficient_next;

    logic [CREDIT_W-1:0]   price_tbl [4];
    logic [CREDIT_W-1:0]   sel_price;
    logic [CREDIT_W-1:0]   coin_value;
    logic [CREDIT_W:0]     coin_sum;
    logic                  coin_any;
    logic                  credit_nonzero;
    logic                  sel_affordable;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_price
            assign price_tbl[gi] = CREDIT_W'(PRICES[gi]);
        end
    endgenerate

    assign sel_price      = price_tbl[sel_id];
    assign sel_affordable = (sel_price <= credit_reg);
    assign coin_any       = quarter | doller;
    assign coin_value     = doller ? DOLLAR_VAL : (quarter ? QUARTER_VAL : '0);
    assign coin_sum       = {1'b0, credit_reg} + {1'b0, coin_value};
    assign credit_nonzero = (credit_reg != '0);

    // State and data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            credit_reg       <= '0;
            dispense_id_reg  <= 2'd0;
            coin_reject_reg  <= 1'b0;
            insufficient_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            dispense_id_reg  <= dispense_id_next;
            coin_reject_reg  <= coin_reject_next;
            insufficient_reg <= insufficient_next;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        dispense_id_next  = dispense_id_reg;
        coin_reject_next  = 1'b0;
        insufficient_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cancel && credit_nonzero) begin
                    // Refund wins; any coin in the same cycle is refused.
                    state_next       = ST_CHANGE;
                    coin_reject_next = coin_any;
                end else if (sel_valid && sel_affordable) begin
                    credit_next      = credit_reg - sel_price;
                    dispense_id_next = sel_id;
                    state_next       = ST_VEND;
                    coin_reject_next = coin_any;
                end else begin
                    // A refused selection does not block a coin.
                    insufficient_next = sel_valid;
                    if (coin_any) begin
                        if (coin_sum <= MAX_EXT) begin
                            credit_next      = coin_sum[CREDIT_W-1:0];
                            // Dollar taken, simultaneous quarter refused.
                            coin_reject_next = quarter & doller;
                        end else begin
                            coin_reject_next = 1'b1;
                        end
                    end
                end
            end

            ST_VEND: begin
                coin_reject_next = coin_any;
                if (dispense_ack) begin
                    state_next = credit_nonzero ? ST_CHANGE : ST_IDLE;
                end
            end

            ST_CHANGE: begin
                coin_reject_next = coin_any;
                if (!credit_nonzero) begin
                    state_next = ST_IDLE;
                end else if (change_ack) begin
                    // Saturate at zero so credit can never wrap.
                    if (credit_reg <= QUARTER_VAL) begin
                        credit_next = '0;
                        state_next  = ST_IDLE;
                    end else begin
                        credit_next = credit_reg - QUARTER_VAL;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        dispense_req = (state_reg == ST_VEND);
        change_req   = (state_reg == ST_CHANGE);
        busy         = (state_reg == ST_VEND) || (state_reg == ST_CHANGE);
    end

    assign dispense_id  = dispense_id_reg;
    assign credit       = credit_reg;
    assign coin_reject  = coin_reject_reg;
    assign insufficient = insufficient_reg;

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Multi-product vending sequencer. Accumulates coin credit, accepts a product selection, and drives the dispenser motor through a req/ack handshake.
- Returns change one quarter at a time through a second req/ack handshake to the coin hopper.
- Sits between the coin acceptor front-end (quarter/dollar detect) and the dispenser/hopper actuators. It replaces single-product fixed-price sequencing.

Parameters:
- PRICE0, 75, price of product 0 in cents (multiple of 25)
- PRICE1, 100, price of product 1 in cents (multiple of 25)
- PRICE2, 125, price of product 2 in cents (multiple of 25)
- PRICE3, 150, price of product 3 in cents (multiple of 25)
- MAX_CREDIT, 200, credit ceiling in cents (multiple of 25, ≤ 2^CREDIT_W−1)
- CREDIT_W, 9, width of credit register

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- quarter  in  1  one-cycle strobe, 25c inserted
- doller  in  1  one-cycle strobe, 100c inserted
- sel_valid  in  1  one-cycle selection strobe
- sel_id  in  2  product index, sampled with sel_valid
- cancel  in  1  one-cycle refund request
- dispense_req  out  1  dispenser request, held until ack
- dispense_id  out  2  product being dispensed, stable while dispense_req=1
- dispense_ack  in  1  dispenser done, single-cycle
- change_req  out  1  request hopper to eject one quarter
- change_ack  in  1  hopper ejected one quarter
- credit  out  CREDIT_W  current credit in cents
- coin_reject  out  1  registered one-cycle pulse, coin refused
- insufficient  out  1  registered one-cycle pulse, selection refused
- busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (synchronous, at rising edge with reset=1): state=IDLE, credit=0, dispense_id=0, coin_reject=0, insufficient=0. Reset mid-handshake aborts the handshake and zeroes credit. No change is returned.
- dispense_req = (state==VEND); change_req = (state==CHANGE); busy = dispense_req|change_req. These are decoded from the state register, so there is no combinational input-to-output path.
- States: IDLE, VEND, CHANGE.
- IDLE, priority order per cycle:
  - cancel: if credit>0, go to CHANGE; else no effect.
  - sel_valid with price(sel_id) ≤ credit: credit −= price, latch dispense_id=sel_id, go to VEND. dispense_req is high the next cycle.
  - sel_valid with price > credit: insufficient pulses the next cycle; state and credit are unchanged.
  - Coin: doller has priority if both strobes are high. The quarter is then refused and coin_reject pulses.
    - If credit+value ≤ MAX_CREDIT: credit += value.
    - Otherwise: coin_reject pulses and credit is unchanged.
  - A coin strobe in the same cycle as an accepted cancel or sel_valid is refused: coin_reject pulses.
- VEND: hold dispense_req and dispense_id. On dispense_ack=1, go to CHANGE if credit>0, else IDLE.
- CHANGE: hold change_req. Each cycle with change_ack=1: credit −= 25. If the new credit is 0, go to IDLE. Back-to-back acks are legal and give one quarter per cycle.
- Outside IDLE: coin strobes produce coin_reject. sel_valid and cancel are ignored, with no pulse.
- Acks arriving in a state that does not own them are ignored.
- Arithmetic: unsigned, width CREDIT_W. Credit never underflows (price ≤ credit is checked; change is decremented only while credit>0) and never exceeds MAX_CREDIT.
- Latencies:
  - Coin strobe to credit update: 1 cycle.
  - Accepted sel_valid to dispense_req: 1 cycle.
  - Ack to req deassert: 1 cycle.

Test Plan:
- Reset, then quarter ×3 → credit 25/50/75. sel_valid id0 → credit 0, dispense_req=1 with dispense_id=0. dispense_ack → IDLE, no change_req.
- doller ×2 (credit 200), sel id2 (125) → credit 75 after ack. CHANGE: change_req held; 3 change_ack → credit 50/25/0, then IDLE. busy is low the cycle after the third ack.
- credit 200, quarter → coin_reject pulse, credit stays 200. Coin strobe during VEND → coin_reject; credit unchanged.
- credit 50, sel id1 (100) → insufficient one-cycle pulse, state IDLE, credit 50. Then cancel → 2 change_req/ack pairs, credit 0.
- Same cycle: cancel + sel_valid + quarter at credit 100 → CHANGE entered, quarter rejected, no dispense. Separately, quarter+doller together at credit 0 → credit 100, coin_reject=1.
- Reset asserted while dispense_req=1 at credit 75 → next cycle IDLE, credit 0, dispense_req=0. A late dispense_ack is ignored.
